set_asso_cache_lru: RTL and testbench
=====================================

Name: set_asso_cache_lru

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with multi-word lines and true-LRU replacement.
- Sits between the CPU data port and main memory. Stalls the CPU through cpu_ready.
- Moves whole lines to and from memory as word-by-word bursts, with a valid/ready handshake on every word.
- Provides hit and miss performance counters.

Parameters:
- WAYS, 4: associativity; power of 2, 2..8.
- SETS, 256: number of sets; power of 2, at least 2.
- LINE_WORDS, 4: 32-bit words per line; power of 2, 1..16.
- Derived: WO = log2(LINE_WORDS), IX = log2(SETS), TAG_W = 32-2-WO-IX.
- Address split: tag [31:2+WO+IX], index [2+WO+IX-1:2+WO], word [2+WO-1:2], byte [1:0] (ignored).

Ports:
- clk, input, 1: clock, rising edge.
- nrst, input, 1: reset, synchronous, active-low.
- cpu_valid, input, 1: request present. Address, op and data are held stable until cpu_ready.
- cpu_op, input, 1: 1 = read, 0 = write.
- cache_addr, input, 32: byte address.
- cpu_write_data, input, 32: write data.
- cpu_ready, output, 1: request completes this cycle.
- cache_data, output, 32: read data; valid when cpu_ready && cpu_op, else 0.
- mem_valid, output, 1: memory word request.
- mem_op, output, 1: 1 = read, 0 = write.
- mem_addr, output, 32: word address, bits [1:0] = 0.
- mem_wdata, output, 32: write-back data.
- mem_ready, input, 1: word accepted / read data valid.
- mem_rdata, input, 32: read data.
- hit_cnt, output, 32: hits since reset.
- miss_cnt, output, 32: misses since reset.

Behaviour:
- Reset (nrst low at clk edge):
  - All V and Dirty bits clear; state IDLE; burst counter 0; both counters 0.
  - LRU age of way w in every set = w.
  - mem_valid = 0 and cpu_ready = 0 from the next cycle. Tag and data arrays are not cleared.
- Lookup is combinational in IDLE. hit = some valid way whose tag matches.
- cpu_ready = cpu_valid && hit && state == IDLE. A hit has zero added latency.
- Write hit: at the edge, write the word, set Dirty, update LRU.
- Read hit: update LRU at the edge.
- hit_cnt increments once per cpu_ready cycle. Both counters wrap modulo 2^32.
- LRU: each way holds a log2(WAYS)-bit age; ages in a set are always a permutation of 0..WAYS-1.
  - On access to way h: every way with age < age[h] increments; age[h] becomes 0.
- Victim selection: the lowest-numbered invalid way; otherwise the way with age WAYS-1. The victim is latched on leaving IDLE.
- State machine:
  - IDLE -> WB: cpu_valid && !hit && victim valid && dirty. miss_cnt increments.
  - IDLE -> FILL: cpu_valid && !hit otherwise. miss_cnt increments.
  - WB: mem_valid = 1, mem_op = 0, mem_addr = {victim tag, index, cnt, 00}, mem_wdata = victim word[cnt].
    - cnt advances on mem_valid && mem_ready.
    - On the last word: cnt = 0, clear victim V and Dirty, go to FILL.
  - FILL: mem_valid = 1, mem_op = 1, mem_addr = {req tag, index, cnt, 00}.
    - Each mem_ready writes mem_rdata into victim word[cnt].
    - On the last word: set V, clear Dirty, write tag, cnt = 0, go to IDLE.
  - IDLE after FILL: the request re-looks-up and hits; it is serviced that cycle and counted as a hit. Miss latency = burst cycles + 1.
- mem_addr, mem_wdata and mem_op hold stable while mem_valid && !mem_ready. mem_valid = 0 in IDLE.
- If cpu_valid drops during WB or FILL, the burst still completes and the line is installed.
- The index is taken from cache_addr, which is guaranteed stable until cpu_ready.
- Reset during a burst abandons it. The partially filled line stays invalid.
- LINE_WORDS = 1: single-word bursts, cnt unused.

Test Plan:
- Defaults, after reset, read 0x1230; memory returns 0xA0,0xA1,0xA2,0xA3 with mem_ready=1.
  - -> FILL reads 0x1230,0x1234,0x1238,0x123C; cpu_ready then cache_data=0xA0.
  - -> miss_cnt=1, hit_cnt=1.
  - -> Next read of 0x1238 is ready the same cycle with 0xA2.
- Write 0x1234 with 0xDEADBEEF -> cpu_ready the same cycle, mem_valid stays 0; read 0x1234 returns 0xDEADBEEF.
- Read 0x2230, 0x3230, 0x4230, then 0x5230 (all index 0x23).
  - -> The 0x5230 miss writes back 0x1230..0x123C with 0xA0,0xDEADBEEF,0xA2,0xA3, then fills 0x5230.
  - -> A later read of 0x1230 misses.
- As above, but read 0x1230 before 0x5230 -> victim is the 0x2230 line (clean); no mem_op=0 traffic; 0x1230 still hits.
- Hold mem_ready low 3 cycles per word during FILL -> mem_addr is stable each word, cpu_ready=0 throughout, and the data is correct.
- Assert nrst for one cycle after 2 FILL words -> next cycle mem_valid=0, miss_cnt=0; re-reading the address misses and does a full 4-word FILL.

Source files
------------

// File: rtl/set_asso_cache_lru.sv
// set_asso_cache_lru: N-way set-associative, write-back, write-allocate cache
// with multi-word lines and true-LRU replacement, between a CPU data port and
// a word-wide memory port.
// Ports:
//   clk, nrst                      clock, synchronous active-low reset
//   cpu_valid/cpu_op/cache_addr/cpu_write_data   CPU request (op 1 = read)
//   cpu_ready, cache_data          request completes / read data
//   mem_valid/mem_op/mem_addr/mem_wdata          memory word request
//   mem_ready, mem_rdata           memory accept / read data
//   hit_cnt, miss_cnt              performance counters (wrap mod 2^32)
module set_asso_cache_lru #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SETS       = 256,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cpu_valid,
    input  logic        cpu_op,
    input  logic [31:0] cache_addr,
    input  logic [31:0] cpu_write_data,
    output logic        cpu_ready,
    output logic [31:0] cache_data,
    output logic        mem_valid,
    output logic        mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int unsigned WO      = $clog2(LINE_WORDS);
    localparam int unsigned IX      = $clog2(SETS);
    localparam int unsigned TAG_W   = 32 - 2 - WO - IX;
    localparam int unsigned AW      = $clog2(WAYS);
    localparam int unsigned CW      = (WO > 0) ? WO : 1;
    localparam int unsigned IDX_LSB = 2 + WO;
    localparam int unsigned TAG_LSB = 2 + WO + IX;

    // Reset ages of one set: way w starts with age w.
    function automatic logic [WAYS*AW-1:0] f_age_init();
        logic [WAYS*AW-1:0] v;
        v = '0;
        for (int unsigned w = 0; w < WAYS; w++) v[w*AW +: AW] = AW'(w);
        return v;
    endfunction
    localparam logic [WAYS*AW-1:0] AGE_INIT = f_age_init();

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

    state_t                               r_state, w_next;
    logic [TAG_W-1:0]                     r_tag  [SETS][WAYS];
    logic [31:0]                          r_data [SETS][WAYS][LINE_WORDS];
    logic [SETS-1:0][WAYS-1:0]            r_valid;
    logic [SETS-1:0][WAYS-1:0]            r_dirty;
    logic [SETS-1:0][WAYS-1:0][AW-1:0]    r_age;
    logic [CW-1:0]                        r_cnt;
    logic [AW-1:0]                        r_vict;

    logic [TAG_W-1:0] w_tag;
    logic [IX-1:0]    w_idx;
    logic [CW-1:0]    w_word;
    logic [CW-1:0]    w_cnt_eff;
    logic             w_hit;
    logic [AW-1:0]    w_hit_way;
    logic             w_inv;
    logic [AW-1:0]    w_inv_way;
    logic [AW-1:0]    w_lru_way;
    logic [AW-1:0]    w_vict;
    logic             w_vict_dirty;
    logic             w_last;
    logic [31:0]      w_line_base;
    logic             w_unused;

    // Address split; the byte offset is ignored.
    assign w_tag     = cache_addr[31 -: TAG_W];
    assign w_idx     = cache_addr[IDX_LSB +: IX];
    assign w_word    = (LINE_WORDS == 1) ? '0 : CW'(cache_addr[31:2]);
    assign w_cnt_eff = (LINE_WORDS == 1) ? '0 : r_cnt;
    assign w_unused  = ^cache_addr[1:0];

    // Combinational lookup and victim choice for the addressed set.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_inv     = 1'b0;
        w_inv_way = '0;
        w_lru_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][AW'(w)] && (r_tag[w_idx][AW'(w)] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = AW'(w);
            end
            if (r_age[w_idx][AW'(w)] == AW'(WAYS - 1)) w_lru_way = AW'(w);
        end
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][AW'(w)]) begin
                w_inv     = 1'b1;
                w_inv_way = AW'(w);
            end
        end
        w_vict = w_inv ? w_inv_way : w_lru_way;
    end

    assign w_vict_dirty = r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict];
    assign w_last       = (r_cnt == CW'(LINE_WORDS - 1));
    assign w_line_base  = (32'(w_idx) << IDX_LSB) | (32'(w_cnt_eff) << 2);

    assign cpu_ready  = cpu_valid && w_hit && (r_state == S_IDLE);
    assign cache_data = (cpu_ready && cpu_op) ? r_data[w_idx][w_hit_way][w_word] : 32'h0;

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and memory-port outputs.
    always_comb begin
        w_next    = r_state;
        mem_valid = 1'b0;
        mem_op    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (cpu_valid && !w_hit) w_next = w_vict_dirty ? S_WB : S_FILL;
            end
            S_WB: begin
                mem_valid = 1'b1;
                mem_op    = 1'b0;
                mem_addr  = (32'(r_tag[w_idx][r_vict]) << TAG_LSB) | w_line_base;
                mem_wdata = r_data[w_idx][r_vict][r_cnt];
                if (mem_ready && w_last) w_next = S_FILL;
            end
            S_FILL: begin
                mem_valid = 1'b1;
                mem_op    = 1'b1;
                mem_addr  = (32'(w_tag) << TAG_LSB) | w_line_base;
                if (mem_ready && w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Control state: valid/dirty/LRU, burst counter, victim, counters.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_valid  <= '0;
            r_dirty  <= '0;
            r_age    <= {SETS{AGE_INIT}};
            r_cnt    <= '0;
            r_vict   <= '0;
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_ready) begin
                        hit_cnt <= hit_cnt + 32'd1;
                        // Younger ways age by one; the accessed way becomes MRU.
                        for (int unsigned w = 0; w < WAYS; w++) begin
                            if (r_age[w_idx][AW'(w)] < r_age[w_idx][w_hit_way])
                                r_age[w_idx][AW'(w)] <= r_age[w_idx][AW'(w)] + 1'b1;
                        end
                        r_age[w_idx][w_hit_way] <= '0;
                        if (!cpu_op) r_dirty[w_idx][w_hit_way] <= 1'b1;
                    end else if (cpu_valid) begin
                        miss_cnt <= miss_cnt + 32'd1;
                        r_vict   <= w_vict;
                    end
                end
                S_WB: begin
                    if (mem_ready) begin
                        if (w_last) begin
                            r_cnt                   <= '0;
                            r_valid[w_idx][r_vict]  <= 1'b0;
                            r_dirty[w_idx][r_vict]  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        if (w_last) begin
                            r_cnt                   <= '0;
                            r_valid[w_idx][r_vict]  <= 1'b1;
                            r_dirty[w_idx][r_vict]  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Tag and data arrays (not cleared by reset).
    always_ff @(posedge clk) begin
        if (nrst) begin
            if (cpu_ready && !cpu_op)
                r_data[w_idx][w_hit_way][w_word] <= cpu_write_data;
            if ((r_state == S_FILL) && mem_ready) begin
                r_data[w_idx][r_vict][r_cnt] <= mem_rdata;
                if (w_last) r_tag[w_idx][r_vict] <= w_tag;
            end
        end
    end
endmodule

// File: tb/tb_set_asso_cache_lru.sv
// tb_set_asso_cache_lru: directed and randomized checks of set_asso_cache_lru
// against a flat-memory + per-set MRU-list model; memory is a latency-programmable
// responder with its own backing store.
module tb_set_asso_cache_lru;
    localparam int unsigned WAYS = 4;
    localparam int unsigned SETS = 256;
    localparam int unsigned LW   = 4;
    localparam int unsigned WO   = 2;

    logic        clk;
    logic        nrst;
    logic        cpu_valid, cpu_op;
    logic [31:0] cache_addr, cpu_write_data;
    logic        cpu_ready;
    logic [31:0] cache_data;
    logic        mem_valid, mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] hit_cnt, miss_cnt;

    set_asso_cache_lru #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_valid(cpu_valid), .cpu_op(cpu_op), .cache_addr(cache_addr),
        .cpu_write_data(cpu_write_data), .cpu_ready(cpu_ready), .cache_data(cache_data),
        .mem_valid(mem_valid), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic op; logic [31:0] addr; logic [31:0] data; } xfer_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned tb_mem  [int unsigned];
    int unsigned ref_mem [int unsigned];
    xfer_t       xlog[$];
    int unsigned mem_lat = 0;
    int          stab_err = 0;

    int unsigned m_q [SETS][$];
    bit          m_dirty [int unsigned];
    int unsigned m_hits = 0, m_miss = 0;

    function automatic int unsigned init_val(input int unsigned a);
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction
    function automatic int unsigned mem_get(input int unsigned a);
        return tb_mem.exists(a) ? tb_mem[a] : init_val(a);
    endfunction
    function automatic int unsigned ref_get(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: mem_ready after mem_lat wait cycles per word.
    initial begin : mem_model
        int          wcnt;
        bit          pend;
        logic [31:0] p_addr, p_wd;
        logic        p_op;
        wcnt = 0; pend = 0; p_addr = '0; p_wd = '0; p_op = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_valid) begin
                if (pend && (mem_addr !== p_addr || mem_op !== p_op ||
                             (!mem_op && mem_wdata !== p_wd)))
                    stab_err++;
                pend = 1; p_addr = mem_addr; p_op = mem_op; p_wd = mem_wdata;
            end
            if (mem_valid && mem_ready) begin
                xlog.push_back({mem_op, mem_addr, mem_op ? mem_rdata : mem_wdata});
                if (!mem_op) tb_mem[mem_addr] = mem_wdata;
                wcnt = 0;
                pend = 0;
            end else if (!mem_valid) begin
                pend = 0;
            end
            @(negedge clk);
            if (!mem_valid) begin
                mem_ready = 1'b0;
                wcnt = 0;
            end else if (wcnt >= int'(mem_lat)) begin
                mem_ready = 1'b1;
                mem_rdata = mem_get(mem_addr);
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end
    end

    // One CPU request; starts at a negedge, returns at a negedge after completion.
    task automatic access(input bit op, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int cyc);
        bit done;
        done = 0; cyc = 0; rd = 'x;
        cpu_valid = 1'b1; cpu_op = op; cache_addr = addr; cpu_write_data = wd;
        while (!done && cyc < 400) begin
            #1;
            if (cpu_ready) begin
                rd = cache_data;
                done = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        n_tests++;
        assert (done) else begin
            n_fail++;
            $error("FAIL timeout addr=%h observed cycles=%0d expected <400", addr, cyc);
        end
        if (done) begin
            @(posedge clk);
            @(negedge clk);
        end
        cpu_valid = 1'b0;
    endtask

    // Predict with the model, run the request, check everything observable.
    task automatic do_access(input bit op, input logic [31:0] addr, input logic [31:0] wd,
                             input int unsigned lat, output logic [31:0] rd, output int cyc);
        int unsigned line, set, vl, wa;
        int          qi;
        bit          wb, evict;
        int          exp_cyc;
        logic [31:0] exp_rd;
        xfer_t       ex[$];
        line = addr >> (2 + WO);
        set  = line % SETS;
        qi = -1; wb = 0; evict = 0; vl = 0;
        for (int i = 0; i < m_q[set].size(); i++) if (m_q[set][i] == line) qi = i;
        exp_rd = op ? ref_get(addr & ~32'h3) : 32'h0;
        if (qi >= 0) begin
            m_q[set].delete(qi);
            exp_cyc = 0;
        end else begin
            if (m_q[set].size() == WAYS) begin
                evict = 1;
                vl = m_q[set].pop_back();
                wb = m_dirty.exists(vl) && m_dirty[vl];
                m_dirty[vl] = 0;
            end
            if (wb) for (int k = 0; k < int'(LW); k++) begin
                wa = (vl << (2 + WO)) + 4 * k;
                ex.push_back({1'b0, wa, ref_get(wa)});
            end
            for (int k = 0; k < int'(LW); k++) begin
                wa = (line << (2 + WO)) + 4 * k;
                ex.push_back({1'b1, wa, ref_get(wa)});
            end
            m_dirty[line] = 0;
            m_miss++;
            exp_cyc = 1 + int'(LW * (lat + 1)) * (wb ? 2 : 1);
        end
        m_q[set].push_front(line);
        m_hits++;
        if (!op) begin
            m_dirty[line] = 1;
            ref_mem[addr & ~32'h3] = wd;
        end
        xlog.delete();
        mem_lat = lat;
        access(op, addr, wd, rd, cyc);
        chk($sformatf("latency@%h", addr), 65'(cyc), 65'(exp_cyc));
        chk($sformatf("data@%h", addr), 65'(rd), 65'(exp_rd));
        chk("hit_cnt", 65'(hit_cnt), 65'(m_hits));
        chk("miss_cnt", 65'(miss_cnt), 65'(m_miss));
        chk($sformatf("xfers@%h", addr), 65'(xlog.size()), 65'(ex.size()));
        for (int i = 0; i < ex.size() && i < xlog.size(); i++)
            chk($sformatf("xfer%0d@%h", i, addr), 65'(xlog[i]), 65'(ex[i]));
    endtask

    initial begin : main
        logic [31:0] rd;
        int          cyc;
        int          nwr;
        logic [31:0] a;
        logic [31:0] wbv[4];
        nrst = 1'b0; cpu_valid = 1'b0; cpu_op = 1'b1; cache_addr = '0; cpu_write_data = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("rst_cpu_ready", 65'(cpu_ready), 65'(0));
        chk("rst_mem_valid", 65'(mem_valid), 65'(0));
        chk("rst_hit_cnt", 65'(hit_cnt), 65'(0));
        chk("rst_miss_cnt", 65'(miss_cnt), 65'(0));
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            tb_mem[32'h1230 + 4 * k]  = 32'hA0 + k;
            ref_mem[32'h1230 + 4 * k] = 32'hA0 + k;
        end

        // First miss: 4-word fill, then serviced as a hit.
        do_access(1, 32'h1230, 0, 0, rd, cyc);
        chk("t1_data", 65'(rd), 65'(32'hA0));
        chk("t1_latency", 65'(cyc), 65'(5));
        for (int k = 0; k < 4; k++)
            chk($sformatf("t1_fill_addr%0d", k), 65'({xlog[k].op, xlog[k].addr}),
                65'({1'b1, 32'h1230 + 32'(4 * k)}));
        chk("t1_miss", 65'(miss_cnt), 65'(1));
        chk("t1_hit", 65'(hit_cnt), 65'(1));
        do_access(1, 32'h1238, 0, 0, rd, cyc);
        chk("t1_hit_data", 65'(rd), 65'(32'hA2));

        // Write hit: zero latency, no memory traffic.
        do_access(0, 32'h1234, 32'hDEADBEEF, 0, rd, cyc);
        chk("t2_wr_latency", 65'(cyc), 65'(0));
        chk("t2_wr_traffic", 65'(xlog.size()), 65'(0));
        do_access(1, 32'h1234, 0, 0, rd, cyc);
        chk("t2_rd_data", 65'(rd), 65'(32'hDEADBEEF));

        // Fill the set; fifth line evicts the dirty LRU line.
        do_access(1, 32'h2230, 0, 0, rd, cyc);
        do_access(1, 32'h3230, 0, 0, rd, cyc);
        do_access(1, 32'h4230, 0, 0, rd, cyc);
        do_access(1, 32'h5230, 0, 0, rd, cyc);
        wbv[0] = 32'hA0; wbv[1] = 32'hDEADBEEF; wbv[2] = 32'hA2; wbv[3] = 32'hA3;
        for (int k = 0; k < 4; k++)
            chk($sformatf("t3_wb%0d", k), 65'(xlog[k]),
                65'({1'b0, 32'h1230 + 32'(4 * k), wbv[k]}));
        chk("t3_fill_addr", 65'({xlog[4].op, xlog[4].addr}), 65'({1'b1, 32'h5230}));
        do_access(1, 32'h1230, 0, 0, rd, cyc);
        chk("t3_reread_misses", 65'(cyc != 0), 65'(1));

        // Touching the oldest line makes the clean 0x2240 line the victim.
        do_access(1, 32'h1240, 0, 0, rd, cyc);
        do_access(0, 32'h1244, 32'h11112222, 0, rd, cyc);
        do_access(1, 32'h2240, 0, 0, rd, cyc);
        do_access(1, 32'h3240, 0, 0, rd, cyc);
        do_access(1, 32'h4240, 0, 0, rd, cyc);
        do_access(1, 32'h1240, 0, 0, rd, cyc);
        do_access(1, 32'h5240, 0, 0, rd, cyc);
        nwr = 0;
        foreach (xlog[i]) if (!xlog[i].op) nwr++;
        chk("t4_no_writeback", 65'(nwr), 65'(0));
        do_access(1, 32'h1244, 0, 0, rd, cyc);
        chk("t4_still_hits", 65'(cyc), 65'(0));
        chk("t4_dirty_data", 65'(rd), 65'(32'h11112222));

        // Slow memory: 3 wait cycles per word.
        do_access(1, 32'h6250, 0, 3, rd, cyc);
        chk("t5_latency", 65'(cyc), 65'(17));
        chk("t5_data", 65'(rd), 65'(init_val(32'h6250)));
        chk("t5_addr_stable", 65'(stab_err), 65'(0));

        // Randomized traffic over three sets with eight tags each.
        for (int n = 0; n < 200; n++) begin
            a = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(8'h23, 8'h25)) << 4)
                | (32'($urandom_range(0, 3)) << 2);
            do_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), rd, cyc);
        end

        // Reset after two fill words abandons the burst.
        xlog.delete();
        mem_lat = 0;
        cpu_valid = 1'b1; cpu_op = 1'b1; cache_addr = 32'h7770;
        for (int k = 0; k < 50 && xlog.size() < 2; k++) @(negedge clk);
        chk("t6_two_words", 65'(xlog.size()), 65'(2));
        nrst = 1'b0;
        cpu_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("t6_mem_valid", 65'(mem_valid), 65'(0));
        chk("t6_miss_cnt", 65'(miss_cnt), 65'(0));
        chk("t6_hit_cnt", 65'(hit_cnt), 65'(0));
        for (int s = 0; s < int'(SETS); s++) m_q[s].delete();
        m_dirty.delete();
        m_hits = 0; m_miss = 0;
        ref_mem.delete();
        foreach (tb_mem[k]) ref_mem[k] = tb_mem[k];
        @(negedge clk);
        do_access(1, 32'h7770, 0, 0, rd, cyc);
        chk("t6_refill_words", 65'(xlog.size()), 65'(4));
        chk("t6_refill_latency", 65'(cyc), 65'(5));
        chk("t6_refill_data", 65'(rd), 65'(init_val(32'h7770)));
        chk("final_addr_stable", 65'(stab_err), 65'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
